// File: rtl/axi_lite_bram_host.sv
// Bridges a single-outstanding BRAM-style word request port onto an AXI-lite master.
// Each request becomes one AXI-lite write or read, answered by a one-cycle resp_valid pulse.
module axi_lite_bram_host #(
  parameter int unsigned          DataWidth       = 64,
  parameter int unsigned          AddrWidth       = 64,
  parameter int unsigned          BRAM_ADDR_WIDTH = 12,
  parameter logic [AddrWidth-1:0] BASE_ADDR       = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DataWidth/8-1:0]     req_we,
  input  logic [BRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [DataWidth-1:0]       req_wdata,
  output logic                       resp_valid,
  output logic [DataWidth-1:0]       resp_rdata,
  output logic                       resp_err,

  output logic [AddrWidth-1:0]       device_aw_addr,
  output logic [2:0]                 device_aw_prot,
  output logic                       device_aw_valid,
  input  logic                       device_aw_ready,
  output logic [DataWidth-1:0]       device_w_data,
  output logic [DataWidth/8-1:0]     device_w_strb,
  output logic                       device_w_valid,
  input  logic                       device_w_ready,
  input  logic [1:0]                 device_b_resp,
  input  logic                       device_b_valid,
  output logic                       device_b_ready,
  output logic [AddrWidth-1:0]       device_ar_addr,
  output logic [2:0]                 device_ar_prot,
  output logic                       device_ar_valid,
  input  logic                       device_ar_ready,
  input  logic [DataWidth-1:0]       device_r_data,
  input  logic [1:0]                 device_r_resp,
  input  logic                       device_r_valid,
  output logic                       device_r_ready,

  output logic [2:0]                 dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a source holds valid and its payload stable until that edge, and never waits on ready.

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ByteShift = $clog2(StrbWidth);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    WRITE_RESP = 3'd2,
    READ       = 3'd3,
    READ_RESP  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   wstrb_q;
  logic                   aw_done_q, w_done_q;
  logic                   resp_valid_q;
  logic [DataWidth-1:0]   resp_rdata_q;
  logic                   resp_err_q;

  logic [AddrWidth-1:0]   word_addr_ext;
  logic [AddrWidth-1:0]   req_byte_addr;
  logic                   accept;
  logic                   aw_hs, w_hs, b_hs, r_hs;

  // Sizing casts give zero-extension or truncation; the adder wraps modulo 2^AddrWidth.
  assign word_addr_ext = AddrWidth'(req_addr);
  assign req_byte_addr = BASE_ADDR + (word_addr_ext << ByteShift);

  assign accept = req_valid && req_ready;
  assign aw_hs  = device_aw_valid && device_aw_ready;
  assign w_hs   = device_w_valid && device_w_ready;
  assign b_hs   = device_b_valid && device_b_ready;
  assign r_hs   = device_r_valid && device_r_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_ready       = 1'b0;
    device_aw_valid = 1'b0;
    device_w_valid  = 1'b0;
    device_b_ready  = 1'b0;
    device_ar_valid = 1'b0;
    device_r_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (|req_we) ? WRITE : READ;
      end
      WRITE: begin
        // AW and W complete independently; each valid drops once its own handshake is done.
        device_aw_valid = !aw_done_q;
        device_w_valid  = !w_done_q;
        if ((aw_done_q || device_aw_ready) && (w_done_q || device_w_ready)) state_d = WRITE_RESP;
      end
      WRITE_RESP: begin
        device_b_ready = 1'b1;
        if (device_b_valid) state_d = IDLE;
      end
      READ: begin
        device_ar_valid = 1'b1;
        if (device_ar_ready) state_d = READ_RESP;
      end
      READ_RESP: begin
        device_r_ready = 1'b1;
        if (device_r_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (accept) begin
      addr_q    <= req_byte_addr;
      wdata_q   <= req_wdata;
      wstrb_q   <= req_we;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
    end
  end

  // Response fields hold their last value between pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= b_hs || r_hs;
      if (b_hs) begin
        resp_rdata_q <= '0;
        resp_err_q   <= device_b_resp[1];
      end else if (r_hs) begin
        resp_rdata_q <= device_r_data;
        resp_err_q   <= device_r_resp[1];
      end
    end
  end

  assign device_aw_addr = addr_q;
  assign device_ar_addr = addr_q;
  assign device_aw_prot = 3'b000;
  assign device_ar_prot = 3'b000;
  assign device_w_data  = wdata_q;
  assign device_w_strb  = wstrb_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/axi_lite_bram_host.md
AXI_LITE_BRAM_HOST -- requirements
Module: axi_lite_bram_host

Interface
REQ-001 SHALL have parameter DataWidth, default 64, meaning the data width in bits for the request port and AXI-lite (8, 16, 32 or 64).
REQ-002 SHALL have parameter AddrWidth, default 64, meaning the AXI-lite byte-address width.
REQ-003 SHALL have parameter BRAM_ADDR_WIDTH, default 12, meaning the word-address width of the request port.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning the AXI byte address that corresponds to request word 0.
REQ-005 SHALL have port clk_i, input, width 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_ni, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, width 1: request present.
REQ-008 SHALL have port req_ready, output, width 1: request accepted when high together with req_valid.
REQ-009 SHALL have port req_we, input, width DataWidth/8: byte write enables; all-zero means read.
REQ-010 SHALL have port req_addr, input, width BRAM_ADDR_WIDTH: word address.
REQ-011 SHALL have port req_wdata, input, width DataWidth: write data.
REQ-012 SHALL have port resp_valid, output, width 1: one-cycle response pulse.
REQ-013 SHALL have port resp_rdata, output, width DataWidth: read data.
REQ-014 SHALL have port resp_err, output, width 1: AXI response was SLVERR or DECERR.
REQ-015 SHALL have the AW channel: device_aw_addr out AddrWidth; device_aw_prot out 3; device_aw_valid out 1; device_aw_ready in 1.
REQ-016 SHALL have the W channel: device_w_data out DataWidth; device_w_strb out DataWidth/8; device_w_valid out 1; device_w_ready in 1.
REQ-017 SHALL have the B channel: device_b_resp in 2; device_b_valid in 1; device_b_ready out 1.
REQ-018 SHALL have the AR channel: device_ar_addr out AddrWidth; device_ar_prot out 3; device_ar_valid out 1; device_ar_ready in 1.
REQ-019 SHALL have the R channel: device_r_data in DataWidth; device_r_resp in 2; device_r_valid in 1; device_r_ready out 1.

Function
REQ-020 SHALL implement the FSM states IDLE, WRITE, WRITE_RESP, READ and READ_RESP, with at most one transaction outstanding.
REQ-021 SHALL drive req_ready = 1 only in IDLE; on acceptance, SHALL go to WRITE if |req_we, else to READ.
REQ-022 SHALL register the address as BASE_ADDR + (req_addr << log2(DataWidth/8)), zero-extended and truncated to AddrWidth with modulo-2^AddrWidth wrap; the same value drives both aw_addr and ar_addr.
REQ-023 SHALL drive aw_prot and ar_prot to 3'b000.
REQ-024 SHALL assert aw_valid and w_valid from the cycle after acceptance, holding them and their payloads stable until each handshake completes independently, in either order or in the same cycle.
REQ-025 SHALL move from WRITE to WRITE_RESP once both the AW and W handshakes have completed.
REQ-026 SHALL assert b_ready only in WRITE_RESP, so that b_valid outside WRITE_RESP is ignored.
REQ-027 SHALL assert ar_valid in READ until ar_ready is seen, then move to READ_RESP.
REQ-028 SHALL assert r_ready only in READ_RESP.
REQ-029 SHALL, on the B handshake, in the next cycle pulse resp_valid for one cycle with resp_err = b_resp[1] and resp_rdata = 0, and return to IDLE.
REQ-030 SHALL, on the R handshake, in the next cycle pulse resp_valid for one cycle with resp_rdata = r_data and resp_err = r_resp[1], and return to IDLE.
REQ-031 SHALL make the response-handshake cycle transition to IDLE, so req_ready is high in the same cycle as resp_valid and back-to-back requests are accepted without a bubble.
REQ-032 SHALL give the minimum latency, with ready/valid immediate, as acceptance at cycle 0, AW/W or AR valid at cycle 1, B/R handshake at cycle 2 and resp_valid at cycle 3.
REQ-033 SHALL provide no back-pressure on the response port, so resp_valid is never stalled.
REQ-034 SHALL hold resp_rdata and resp_err at their last values between pulses.

Reset
REQ-035 SHALL, while rst_ni = 0, immediately force state IDLE, all AXI valid and ready outputs to 0, resp_valid, resp_rdata and resp_err to 0, and the address, data and strobe registers to 0, with req_ready = 1.
REQ-036 SHALL, on reset mid-transaction, abandon the transaction, produce no resp_valid for it, and accept a new request normally after reset deasserts.

Verification
REQ-037 SHALL be verified with: write req_addr=0x10, we=0xFF, wdata=0x1122334455667788, BASE_ADDR=0x8000_0000, all ready=1, b_resp=OKAY -> aw_addr=0x80000080, w_strb=0xFF, resp_valid at cycle 3, resp_err=0.
REQ-038 SHALL be verified with: read req_addr=3, r_data=0xDEADBEEF, r_resp=SLVERR(2'b10) -> ar_addr=0x18, resp_rdata=0xDEADBEEF, resp_err=1, a single-cycle pulse.
REQ-039 SHALL be verified with: write where w_ready arrives 4 cycles before aw_ready -> w_valid drops after its handshake, aw_valid is held stable, b_ready rises only after the AW handshake, and exactly one resp_valid is seen.
REQ-040 SHALL be verified with: b_valid driven high in WRITE before the AW/W handshakes complete -> b_ready stays 0 and it is not consumed until WRITE_RESP.
REQ-041 SHALL be verified with: back-to-back read then write with req_valid held high -> second request accepted in the resp_valid cycle, with no bubble.
REQ-042 SHALL be verified with: rst_ni low while in READ_RESP -> r_ready=0 and ar_valid=0 immediately, no resp_valid, and req_ready=1; after release, a new read completes normally.
